rx_sd_ctrl: RTL
===============

// Module: rx_sd_ctrl
// PURPOSE
// Receiver sequencer around the signal-strength detector (SD). Owns the SD's
// threshold/window configuration and reset, and qualifies SD_flag into a receive
// window. It drives rx_en (carrier/frame-sync enable) and sync_rst for downstream
// sync logic, and recovers from lost frames via a frame timeout. Runs in the 16.384 MHz Rx domain.
// PARAMETERS
// WIDTH            16     SD threshold width (matches SD datapath)
// MAX_WINDOW_WIDTH 8      SD window width
// CNT_WIDTH        16     settle/timeout counter width
// DEF_THRESHOLD    16'd2048  threshold driven after reset
// DEF_WINDOW       8'd64     window driven after reset
// PORTS
// clk           in  1      clock
// rst           in  1      reset: synchronous, active-high
// cfg_threshold in  WIDTH  requested SD threshold
// cfg_window    in  MWW    requested SD window (cycles)
// cfg_settle    in  CNT_W  cycles SD_flag must hold before rx_en
// cfg_timeout   in  CNT_W  max cycles between frame_done in ACTIVE; 0 = off
// cfg_update    in  1      1-cycle pulse: sample all cfg_* into pending shadow
// SD_flag       in  1      strength flag from the SD
// frame_done    in  1      1-cycle pulse per frame decoded downstream
// sd_threshold  out WIDTH  applied threshold to SD (registered)
// sd_window     out MWW    applied window to SD (registered)
// sd_rst        out 1      SD reset
// rx_en         out 1      receive chain enable
// sync_rst      out 1      1-cycle reset pulse to carrier/frame sync
// timeout_pulse out 1      1-cycle pulse on frame timeout
// state         out 3      current FSM state (debug)
// BEHAVIOUR
// - Reset: state=INIT, sd_threshold=DEF_THRESHOLD, sd_window=DEF_WINDOW,
//   sd_rst=1, rx_en=0, sync_rst=0, timeout_pulse=0, pending=0, counters=0.
//   Shadow settle=0, timeout=0. All outputs are registered.
// - cfg_update in any state: capture cfg_* to shadow, set pending. Repeated updates overwrite.
// - INIT(0): sd_rst=1 for exactly 2 cycles, then IDLE. sd_rst=0 elsewhere.
// - IDLE(1): if pending -> copy shadow to sd_threshold/sd_window, clear pending,
//   go INIT (pending beats SD_flag on the same cycle). Else SD_flag=1 -> SETTLE, cnt=0.
// - SETTLE(2): SD_flag=0 -> IDLE. Else cnt++; cnt==settle -> ACTIVE,
//   assert sync_rst that same cycle. settle=0 -> ACTIVE one cycle after entry.
// - ACTIVE(3): rx_en=1. frame_done clears tcnt, else tcnt++ (saturating).
//   SD_flag=0 -> HOLDOFF. Else timeout!=0 && tcnt==timeout-1 -> HOLDOFF +
//   timeout_pulse. SD drop has priority over timeout; frame_done on the same
//   cycle as timeout cancels the timeout.
// - HOLDOFF(4): rx_en=0; wait sd_window cycles (window=0 -> 1 cycle), then IDLE.
// - rx_en registered: rises the cycle after entering ACTIVE, falls the cycle after leaving.
// - pending is never applied outside IDLE, so thresholds never change mid-frame.
// - rst mid-operation: immediate return to reset values; pending discarded.
// - Unused state encodings (5-7) -> INIT.
// STRUCTURE
// - Shared package/header: state encodings (ST_INIT..ST_HOLDOFF), INIT_RST_CYCLES=2.
// - Single module; no sub-module (one FSM + shadow regs + two counters).
//   Instantiated beside Rx_SD: sd_threshold/sd_window/sd_rst feed its
//   RX_SD_THRESHOLD/RX_SD_WINDOW/rst.
// TESTING
// 1 Reset released -> sd_rst high 2 cycles, state IDLE, sd_threshold=2048, window=64.
// 2 cfg_update(thr=500,win=16,settle=10) in IDLE -> INIT, sd_threshold=500, sd_rst 2 cycles.
// 3 settle=10; SD_flag high 5 cycles then low -> back to IDLE, rx_en never 1;
//   held 11 cycles -> ACTIVE, one sync_rst pulse, rx_en=1.
// 4 ACTIVE, timeout=100, no frame_done -> timeout_pulse at cycle 100, HOLDOFF,
//   IDLE after 16 cycles; frame_done every 50 cycles -> no timeout.
// 5 cfg_update during ACTIVE -> thresholds unchanged until IDLE, then applied via INIT;
//   cfg_update + SD_flag rise same IDLE cycle -> INIT taken.
// 6 rst asserted in SETTLE with pending=1 -> reset values, pending dropped.

Source files
------------

// File: rtl/rx_sd_ctrl_pkg.sv
// rx_sd_ctrl_pkg: state encodings and fixed timing constants for the Rx SD sequencer.
// Revision 1.0
`default_nettype none

package rx_sd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  localparam int INIT_RST_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/rx_sd_ctrl.sv
// rx_sd_ctrl: sequences the signal-strength detector config/reset and qualifies SD_flag into rx_en.
// Revision 1.0
`default_nettype none

module rx_sd_ctrl
  import rx_sd_ctrl_pkg::*;
#(
  parameter int                          WIDTH            = 16,
  parameter int                          MAX_WINDOW_WIDTH = 8,
  parameter int                          CNT_WIDTH        = 16,
  parameter logic [WIDTH-1:0]            DEF_THRESHOLD    = WIDTH'(2048),
  parameter logic [MAX_WINDOW_WIDTH-1:0] DEF_WINDOW       = MAX_WINDOW_WIDTH'(64)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            cfg_threshold,
  input  logic [MAX_WINDOW_WIDTH-1:0] cfg_window,
  input  logic [CNT_WIDTH-1:0]        cfg_settle,
  input  logic [CNT_WIDTH-1:0]        cfg_timeout,
  input  logic                        cfg_update,
  input  logic                        SD_flag,
  input  logic                        frame_done,
  output logic [WIDTH-1:0]            sd_threshold,
  output logic [MAX_WINDOW_WIDTH-1:0] sd_window,
  output logic                        sd_rst,
  output logic                        rx_en,
  output logic                        sync_rst,
  output logic                        timeout_pulse,
  output logic [2:0]                  state
);

  state_t                        r_state;
  logic [CNT_WIDTH-1:0]          r_cnt;
  logic [CNT_WIDTH-1:0]          r_tcnt;
  logic [WIDTH-1:0]              r_shd_thr;
  logic [MAX_WINDOW_WIDTH-1:0]   r_shd_win;
  logic [CNT_WIDTH-1:0]          r_shd_settle;
  logic [CNT_WIDTH-1:0]          r_shd_timeout;
  logic                          r_pending;
  logic [WIDTH-1:0]              r_sd_threshold;
  logic [MAX_WINDOW_WIDTH-1:0]   r_sd_window;
  logic                          r_sd_rst;
  logic                          r_rx_en;
  logic                          r_sync_rst;
  logic                          r_timeout_pulse;

  logic                          w_apply;
  logic [WIDTH-1:0]              w_app_thr;
  logic [MAX_WINDOW_WIDTH-1:0]   w_app_win;
  logic                          w_tmo_hit;
  logic                          w_hold_done;
  logic                          w_tcnt_max;

  // An update arriving in IDLE is applied at once so it beats an SD_flag rise on the same cycle.
  assign w_apply     = r_pending | cfg_update;
  assign w_app_thr   = cfg_update ? cfg_threshold : r_shd_thr;
  assign w_app_win   = cfg_update ? cfg_window    : r_shd_win;
  assign w_tmo_hit   = (r_shd_timeout != '0) && (r_tcnt == r_shd_timeout - CNT_WIDTH'(1));
  assign w_hold_done = (r_sd_window == '0) ||
                       (r_cnt == CNT_WIDTH'(r_sd_window) - CNT_WIDTH'(1));
  assign w_tcnt_max  = &r_tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_INIT;
      r_cnt           <= '0;
      r_tcnt          <= '0;
      r_shd_thr       <= DEF_THRESHOLD;
      r_shd_win       <= DEF_WINDOW;
      r_shd_settle    <= '0;
      r_shd_timeout   <= '0;
      r_pending       <= 1'b0;
      r_sd_threshold  <= DEF_THRESHOLD;
      r_sd_window     <= DEF_WINDOW;
      r_sd_rst        <= 1'b1;
      r_rx_en         <= 1'b0;
      r_sync_rst      <= 1'b0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_sync_rst      <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_rx_en         <= (r_state == ST_ACTIVE);

      if (cfg_update) begin
        r_shd_thr     <= cfg_threshold;
        r_shd_win     <= cfg_window;
        r_shd_settle  <= cfg_settle;
        r_shd_timeout <= cfg_timeout;
        r_pending     <= 1'b1;
      end

      case (r_state)
        ST_INIT: begin
          if (r_cnt == CNT_WIDTH'(INIT_RST_CYCLES - 1)) begin
            r_state  <= ST_IDLE;
            r_sd_rst <= 1'b0;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end

        ST_IDLE: begin
          if (w_apply) begin
            r_sd_threshold <= w_app_thr;
            r_sd_window    <= w_app_win;
            r_pending      <= 1'b0;
            r_state        <= ST_INIT;
            r_sd_rst       <= 1'b1;
            r_cnt          <= '0;
          end else if (SD_flag) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
          end
        end

        ST_SETTLE: begin
          if (!SD_flag) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == r_shd_settle) begin
            r_state    <= ST_ACTIVE;
            r_sync_rst <= 1'b1;
            r_tcnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end

        ST_ACTIVE: begin
          if (frame_done) begin
            r_tcnt <= '0;
          end else if (!w_tcnt_max) begin
            r_tcnt <= r_tcnt + CNT_WIDTH'(1);
          end
          if (!SD_flag) begin
            r_state <= ST_HOLDOFF;
            r_cnt   <= '0;
          end else if (w_tmo_hit && !frame_done) begin
            r_state         <= ST_HOLDOFF;
            r_timeout_pulse <= 1'b1;
            r_cnt           <= '0;
          end
        end

        ST_HOLDOFF: begin
          if (w_hold_done) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end

        default: begin
          r_state  <= ST_INIT;
          r_sd_rst <= 1'b1;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign sd_threshold  = r_sd_threshold;
  assign sd_window     = r_sd_window;
  assign sd_rst        = r_sd_rst;
  assign rx_en         = r_rx_en;
  assign sync_rst      = r_sync_rst;
  assign timeout_pulse = r_timeout_pulse;
  assign state         = r_state;

endmodule

`default_nettype wire
